// File: rtl/asp_net_arbiter.sv
// asp_net_arbiter
//   Round-robin transmit arbiter sharing one network link among num_ports
//   ASP requesters. A granted word is latched, sent with a one-cycle ready
//   pulse, and retransmitted on ACK timeout up to max_retries times before
//   being dropped.
//
// Ports
//   clk                     rising-edge clock
//   reset                   asynchronous, active-low reset
//   req_data_ready_in       per-port "word available"
//   req_data_tag_in         packed words, port i at [i*W +: W]
//   req_ACK_out             one-hot, one-cycle "word taken" pulse
//   network_data_ready_out  one-cycle send pulse
//   network_data_tag_out    latched word (held between sends)
//   network_ACK_in          network acknowledge
//   grant_id_out            port index of current/last transaction
//   busy_out                high while a transaction is in flight
//   sent_ok_out             one-cycle pulse on accepted ACK
//   timeout_error_out       one-cycle pulse when a word is dropped
module asp_net_arbiter #(
    parameter int data_size   = 32,
    parameter int tag_size    = 8,
    parameter int num_ports   = 4,
    parameter int ack_timeout = 16,
    parameter int max_retries = 3
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [num_ports-1:0]                        req_data_ready_in,
    input  logic [num_ports*(data_size+tag_size)-1:0]   req_data_tag_in,
    output logic [num_ports-1:0]                        req_ACK_out,
    output logic                                        network_data_ready_out,
    output logic [data_size+tag_size-1:0]               network_data_tag_out,
    input  logic                                        network_ACK_in,
    output logic [$clog2(num_ports)-1:0]                grant_id_out,
    output logic                                        busy_out,
    output logic                                        sent_ok_out,
    output logic                                        timeout_error_out
);

    localparam int W  = data_size + tag_size;
    localparam int GW = $clog2(num_ports);
    localparam int TW = $clog2(ack_timeout);
    // A zero-retry build still needs a 1-bit counter.
    localparam int RW = (max_retries > 0) ? $clog2(max_retries + 1) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(ack_timeout - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(max_retries);

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          ptr_q, ptr_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [RW-1:0]          retry_q, retry_d;
    logic [W-1:0]           tag_q, tag_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [num_ports-1:0]   req_ack_q, req_ack_d;
    logic                   ndr_q, ndr_d;
    logic                   ok_q, ok_d;
    logic                   to_q, to_d;

    logic                   found;
    logic [GW-1:0]          pick;

    // Round-robin search: first ready port strictly after the pointer,
    // wrapping, so the last-granted port has lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int k = 1; k <= num_ports; k++) begin
            int j;
            j = (int'(ptr_q) + k) % num_ports;
            if (!found && req_data_ready_in[j]) begin
                found = 1'b1;
                pick  = GW'(j);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        tag_d     = tag_q;
        grant_d   = grant_q;
        req_ack_d = '0;
        ndr_d     = 1'b0;
        ok_d      = 1'b0;
        to_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // ACK seen while idle is deliberately ignored.
                if (found) begin
                    state_d         = WAIT_ACK;
                    ptr_d           = pick;
                    grant_d         = pick;
                    tag_d           = req_data_tag_in[pick*W +: W];
                    req_ack_d[pick] = 1'b1;
                    ndr_d           = 1'b1;
                    timer_d         = '0;
                    retry_d         = '0;
                end
            end
            WAIT_ACK: begin
                // ACK wins over a simultaneous timeout.
                if (network_ACK_in) begin
                    ok_d    = 1'b1;
                    state_d = IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        timer_d = '0;
                        ndr_d   = 1'b1;
                    end else begin
                        to_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= GW'(num_ports - 1);
            timer_q   <= '0;
            retry_q   <= '0;
            tag_q     <= '0;
            grant_q   <= '0;
            req_ack_q <= '0;
            ndr_q     <= 1'b0;
            ok_q      <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            retry_q   <= retry_d;
            tag_q     <= tag_d;
            grant_q   <= grant_d;
            req_ack_q <= req_ack_d;
            ndr_q     <= ndr_d;
            ok_q      <= ok_d;
            to_q      <= to_d;
        end
    end

    assign req_ACK_out            = req_ack_q;
    assign network_data_ready_out = ndr_q;
    assign network_data_tag_out   = tag_q;
    assign grant_id_out           = grant_q;
    assign busy_out               = (state_q == WAIT_ACK);
    assign sent_ok_out            = ok_q;
    assign timeout_error_out      = to_q;

endmodule

// File: tb/tb_asp_net_arbiter.sv
// Directed bench for asp_net_arbiter (default parameters).
// Output snapshot order: {req_ACK, ready, grant, busy, ok, timeout, tag}.
module tb_asp_net_arbiter;

    localparam logic [39:0] W0 = 40'h01_11111111;
    localparam logic [39:0] W1 = 40'h02_22222222;
    localparam logic [39:0] W2 = 40'hAB_DEADBEEF;
    localparam logic [39:0] W3 = 40'h04_44444444;

    logic         clk;
    logic         reset;
    logic [3:0]   rdy;
    logic [159:0] tags;
    logic [3:0]   req_ack;
    logic         ndr;
    logic [39:0]  ntag;
    logic         ack;
    logic [1:0]   gid;
    logic         busy;
    logic         ok;
    logic         terr;

    asp_net_arbiter dut (
        .clk                    (clk),
        .reset                  (reset),
        .req_data_ready_in      (rdy),
        .req_data_tag_in        (tags),
        .req_ACK_out            (req_ack),
        .network_data_ready_out (ndr),
        .network_data_tag_out   (ntag),
        .network_ACK_in         (ack),
        .grant_id_out           (gid),
        .busy_out               (busy),
        .sent_ok_out            (ok),
        .timeout_error_out      (terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  rdy;
        logic        ack;
        logic [49:0] exp;
    } vec_t;

    vec_t tv[$];
    int   nvec = 0;
    int   nerr = 0;

    function automatic logic [49:0] mk(logic [3:0] ra, logic n, logic [1:0] g,
                                       logic b, logic o, logic t, logic [39:0] w);
        return {ra, n, g, b, o, t, w};
    endfunction

    function automatic logic [49:0] outs();
        return {req_ack, ndr, gid, busy, ok, terr, ntag};
    endfunction

    function automatic logic [39:0] word_of(int p);
        case (p)
            0:       return W0;
            1:       return W1;
            2:       return W2;
            default: return W3;
        endcase
    endfunction

    task automatic add(logic r, logic [3:0] rd, logic a, logic [49:0] e);
        vec_t v;
        v.rst = r; v.rdy = rd; v.ack = a; v.exp = e;
        tv.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [49:0] act, logic [49:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; rdy = '0; ack = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int pq[$];
        int okc, toc, toat, bad, np;

        reset = 1'b0;
        rdy   = '0;
        ack   = 1'b0;
        tags  = {W3, W2, W1, W0};

        // Single request from port 2, ACK sampled 3 edges after the grant edge
        add(0, 4'b0000, 0, mk(4'b0000, 0, 0, 0, 0, 0, 40'h0));
        add(1, 4'b0100, 0, mk(4'b0100, 1, 2, 1, 0, 0, W2));
        add(1, 4'b0000, 0, mk(4'b0000, 0, 2, 1, 0, 0, W2));
        add(1, 4'b0000, 0, mk(4'b0000, 0, 2, 1, 0, 0, W2));
        add(1, 4'b0000, 1, mk(4'b0000, 0, 2, 0, 1, 0, W2));
        add(1, 4'b0000, 0, mk(4'b0000, 0, 2, 0, 0, 0, W2));
        // Round robin from a fresh reset: 0,1,2,3,0 with one idle cycle between
        add(0, 4'b0000, 0, mk(4'b0000, 0, 0, 0, 0, 0, 40'h0));
        for (int i = 0; i < 5; i++) begin
            int g;
            logic [3:0] oh;
            g  = i % 4;
            oh = 4'b0001 << g;
            add(1, 4'b1111, 0, mk(oh, 1, 2'(g), 1, 0, 0, word_of(g)));
            add(1, 4'b1111, 1, mk(4'b0000, 0, 2'(g), 0, 1, 0, word_of(g)));
        end
        add(1, 4'b0000, 0, mk(4'b0000, 0, 0, 0, 0, 0, W0));

        #2;
        chk("reset_state", outs(), mk(4'b0000, 0, 0, 0, 0, 0, 40'h0));

        for (int i = 0; i < tv.size(); i++) begin
            reset = tv[i].rst;
            rdy   = tv[i].rdy;
            ack   = tv[i].ack;
            tick();
            chk($sformatf("vec%0d", i), outs(), tv[i].exp);
        end

        // Timeout / retry: port 1, no ACK ever
        do_reset();
        rdy = 4'b0010;
        tick();
        chk("to_grant", outs(), mk(4'b0010, 1, 1, 1, 0, 0, W1));
        rdy = '0;
        pq.delete(); pq.push_back(0);
        okc = 0; toc = 0; toat = -1; bad = 0;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (ndr) begin
                pq.push_back(c);
                if (ntag !== W1) bad++;
            end
            if (ok) okc++;
            if (terr) begin toc++; toat = c; end
        end
        chk_int("to_pulse_count", pq.size(), 4);
        for (int i = 0; i < pq.size() && i < 4; i++)
            chk_int($sformatf("to_pulse%0d_at", i), pq[i], 16 * i);
        chk_int("to_word_stable", bad, 0);
        chk_int("to_err_count", toc, 1);
        chk_int("to_err_at", toat, 64);
        chk_int("to_no_ok", okc, 0);

        // ACK on the 16th edge after the send: accepted, no retransmit
        rdy = 4'b1000;
        tick();
        chk("b16_grant", outs(), mk(4'b1000, 1, 3, 1, 0, 0, W3));
        rdy = '0;
        np = 0; okc = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (ndr) np++;
            if (ok || terr) okc++;
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("b16_ack", outs(), mk(4'b0000, 0, 3, 0, 1, 0, W3));
        chk_int("b16_no_early_pulse", np + okc, 0);

        // ACK on the same edge as the final timeout: ACK wins
        rdy = 4'b0001;
        tick();
        chk("b64_grant", outs(), mk(4'b0001, 1, 0, 1, 0, 0, W0));
        rdy = '0;
        np = 0; okc = 0; toc = 0;
        for (int c = 1; c <= 63; c++) begin
            tick();
            if (ndr) np++;
            if (ok) okc++;
            if (terr) toc++;
        end
        ack = 1'b1;
        tick();
        chk("b64_ack_wins", outs(), mk(4'b0000, 0, 0, 0, 1, 0, W0));
        chk_int("b64_retries", np, 3);
        chk_int("b64_no_status", okc + toc, 0);

        // Spurious ACK while idle (ack still high from above)
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("spur%0d", c), outs(), mk(4'b0000, 0, 0, 0, 0, 0, W0));
        end
        ack = 1'b0;

        // Reset mid-transaction, then pointer restarts at port 0
        rdy = 4'b0100;
        tick();
        chk("abort_grant", outs(), mk(4'b0100, 1, 2, 1, 0, 0, W2));
        rdy = '0;
        tick();
        tick();
        #2 reset = 1'b0;
        #1 chk("abort_async", outs(), mk(4'b0000, 0, 0, 0, 0, 0, 40'h0));
        tick();
        chk("abort_held", outs(), mk(4'b0000, 0, 0, 0, 0, 0, 40'h0));
        rdy   = 4'b1001;
        reset = 1'b1;
        tick();
        chk("post_reset_grant", outs(), mk(4'b0001, 1, 0, 1, 0, 0, W0));
        rdy = '0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/asp_net_arbiter.md
# asp_net_arbiter

Round-robin transmit arbiter that shares one network link among `num_ports` ASP instances. It accepts one data+tag word at a time from any ready ASP and drives it onto the network with a single-cycle ready pulse. It then waits for the network ACK, retransmitting on timeout up to a retry limit. It sits between the ASP `network_data_ready_out`/`network_data_tag_out` outputs and the shared network interface.

## Interface
Parameters:
- `data_size`, 32, payload width.
- `tag_size`, 8, tag width; word width W = data_size+tag_size.
- `num_ports`, 4, number of requesting ASPs (≥2); GW = $clog2(num_ports).
- `ack_timeout`, 16, cycles waited for ACK per send (≥2).
- `max_retries`, 3, retransmissions after the first send before the word is dropped.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_data_ready_in`  in  num_ports  per-port "word available".
- `req_data_tag_in`  in  num_ports*W  packed words; port i = bits [i*W +: W].
- `req_ACK_out`  out  num_ports  one-hot, one-cycle "word taken" pulse.
- `network_data_ready_out`  out  1  one-cycle send pulse.
- `network_data_tag_out`  out  W  latched word; valid when ready pulses, held otherwise.
- `network_ACK_in`  in  1  network acknowledge.
- `grant_id_out`  out  GW  port index of current/last transaction.
- `busy_out`  out  1  high whenever state ≠ IDLE.
- `sent_ok_out`  out  1  one-cycle pulse on accepted ACK.
- `timeout_error_out`  out  1  one-cycle pulse when a word is dropped.

## Operation
- All outputs are registered.
- Reset (`reset`=0, asynchronous):
  - State is IDLE. All outputs are 0, including `network_data_tag_out` and `grant_id_out`.
  - The round-robin pointer is set to num_ports-1, so port 0 has first priority.
  - Timer and retry count are 0.
- FSM states: IDLE, WAIT_ACK.
- IDLE, on an edge where any `req_data_ready_in` bit is high:
  - Choose the first ready port searching upward from pointer+1, wrapping at num_ports.
  - Latch its word into `network_data_tag_out`.
  - Set `req_ACK_out[i]` = 1, `network_data_ready_out` = 1, `grant_id_out` = i, pointer = i.
  - Clear timer and retry count; go to WAIT_ACK.
- IDLE with no port ready: hold all outputs and stay in IDLE.
- WAIT_ACK, evaluated on each edge:
  - `req_ACK_out` and `network_data_ready_out` return to 0 one cycle after being set.
  - If `network_ACK_in` = 1: `sent_ok_out` = 1, go to IDLE. ACK has priority over timeout on the same edge.
  - Else if timer = ack_timeout-1 and retry count < max_retries: retry count +1, timer = 0, `network_data_ready_out` = 1. The word is unchanged.
  - Else if timer = ack_timeout-1 (retries exhausted): `timeout_error_out` = 1, go to IDLE, word dropped.
  - Else: timer +1.
- `network_ACK_in` sampled in IDLE is ignored. An ACK at the edge that ends the send pulse is accepted.
- Requester rule: hold `req_data_ready_in` and the word stable until `req_ACK_out[i]` pulses. Afterwards present the next word or drop ready.
- Reset mid-transaction aborts immediately. The in-flight word is lost; no `sent_ok_out` or `timeout_error_out` pulse.

## Timing
- Grant latency: a ready port sampled at edge E0 (in IDLE) produces `req_ACK_out` and `network_data_ready_out` high during E0→E1.
- ACK window: ACK is sampled at edges E1..E(ack_timeout).
- Retransmit schedule: sends go out after E0, E16, E32, E48 (defaults). The drop occurs at E64, with `timeout_error_out` high during E64→E65.
- Completion at edge Ek returns to IDLE. The earliest next grant is Ek+1, so there is 1 idle cycle minimum between transactions.
- `busy_out` is high from E0 through the completion edge.
- Timer width is $clog2(ack_timeout). The retry counter is wide enough for max_retries. Neither counter wraps; both saturate by construction.

## Test plan
- Single request: port 2 ready with 40'hAB_DEADBEEF; ACK 3 cycles after the send.
  - Expect `req_ACK_out` = 4'b0100 and one `network_data_ready_out` pulse carrying that word.
  - Expect `grant_id_out` = 2, `sent_ok_out` pulse, no retry.
- Round-robin: all 4 ports held ready; every send ACKed after 1 cycle.
  - Expect grant order 0,1,2,3,0.
  - Expect each `req_ACK_out` one-hot and back-to-back transactions separated by exactly 1 IDLE cycle.
- Timeout/retry (defaults): port 1 requests; ACK never arrives.
  - Expect exactly 4 `network_data_ready_out` pulses, 16 cycles apart, all with the same word.
  - Expect `timeout_error_out` 64 cycles after the grant edge and no `sent_ok_out`.
- Boundary ACK: ACK arrives exactly on the 16th edge after a send.
  - Expect `sent_ok_out` and no retransmission.
  - Repeat with ACK on the same edge as the retry-limit timeout: expect `sent_ok_out` and no `timeout_error_out`.
- Spurious ACK / reset abort:
  - ACK pulses while IDLE: expect no output change.
  - `reset` low during WAIT_ACK: expect all outputs 0 immediately (asynchronously) and no status pulse.
  - After release with port 0 ready: expect port 0 granted first.
